adder_arbiter: RTL
==================

# adder_arbiter

Sequential controller that shares the single 32-bit `Adder` datapath among up to `NREQ` requesters (PC+4, branch target, address generation, debug). Arbitrates requests round-robin, latches the winner's operands, drives the shared adder, registers the sum with its requester ID and holds it under a valid/ready handshake until consumed. It sits between the requesting datapath units and the one `Adder` instance.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, 2, requester-ID width, equal to clog2(`NREQ`).
- `clk_in` input 1: clock, rising edge.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `req_in` input NREQ: per-requester request level; held until the matching grant bit pulses.
- `data1_in` input NREQ*32: operand A, requester k at bits [32k+31:32k].
- `data2_in` input NREQ*32: operand B, same packing.
- `grant_out` output NREQ: one-hot, 1-cycle pulse; operands of that requester captured this edge.
- `data_out` output 32: registered sum, modulo 2^32.
- `carry_out` output 1: carry out of bit 31 for `data_out`.
- `id_out` output IDW: requester index owning `data_out`.
- `valid_out` output 1: `data_out`/`carry_out`/`id_out` valid.
- `ready_in` input 1: consumer accepts the result when `valid_out & ready_in`.
- `busy_out` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, DONE; 2-bit encoding.
- IDLE: if `req_in != 0`, pick the first set bit at or after `ptr`, wrapping modulo NREQ. Pulse `grant_out[w]` combinationally in this cycle. At the edge, latch `data1_in[w]`, `data2_in[w]` and `w`, and go to EXEC. If `req_in == 0`, stay in IDLE and leave `grant_out` at 0.
- EXEC: latched operands feed the shared `Adder`. At the edge, register the 33-bit sum into `{carry_out, data_out}`, set `valid_out`, and go to DONE.
- DONE: hold all outputs stable while `ready_in == 0`. On `valid_out & ready_in`, clear `valid_out`, set `ptr = (w+1) mod NREQ`, and go to IDLE.
- The pointer advances only on completion, so a granted requester has lowest priority for the next arbitration.
- Requests arriving in EXEC/DONE wait; no grant is issued outside IDLE.
- A requester may drop `req_in` after its grant; the latched operands are unaffected.
- `req_in` deasserted before a grant: no transaction for that requester.
- Arithmetic: unsigned add, wraps modulo 2^32. Examples: 0xFFFFFFFF + 1 gives 0 with carry 1; 0x7FFFFFFF + 1 gives 0x80000000 with carry 0. No overflow flag.
- Reset, asserted at any time including mid-EXEC or DONE, aborts the transaction: the result is lost and not re-issued. Reset values: state = IDLE, `ptr` = 0, `grant_out` = 0, `valid_out` = 0, `data_out` = 0, `carry_out` = 0, `id_out` = 0, `busy_out` = 0.

## Timing
- Grant in cycle t (IDLE) → `valid_out` high from cycle t+2.
- Result accepted in cycle t+2 (ready high) → state is IDLE in t+3, next grant possible in t+3.
- Peak throughput: one add per 3 cycles. With k simultaneous requesters the worst-case wait is (NREQ−1)×3 cycles plus consumer stall.
- `grant_out` is the only combinational output; it depends on `req_in`, state and `ptr`. All other outputs come straight from registers.
- Reset deassertion is synchronised externally; the block makes no decision in the cycle `rst_n_in` rises.

## Structure
- Shared package `adder_arb_pkg`: state encoding constants (IDLE = 0, EXEC = 1, DONE = 2) and the default `NREQ`/`IDW`.
- Sub-module `rr_pick`: purely combinational round-robin priority picker. Inputs are `req` and `ptr`; outputs are one-hot `gnt`, `idx` and `any`. Unit-testable on its own.
- The existing `Adder` is instantiated once, unmodified. The carry is computed beside it from the top bits as `{1'b0,a}+{1'b0,b}`, bit 32. The adder is not widened.

## Test plan
- Reset, then `req_in` = 0001 with A = 3, B = 4 → `grant_out` = 0001 in the request cycle. Two cycles later `valid_out` = 1, `data_out` = 7, `carry_out` = 0, `id_out` = 0.
- A = 0xFFFFFFFF, B = 1 → `data_out` = 0, `carry_out` = 1. A = 0x7FFFFFFF, B = 1 → `data_out` = 0x80000000, `carry_out` = 0.
- `req_in` = 1111 held continuously, `ready_in` = 1 → grants in order 0,1,2,3,0, spaced exactly 3 cycles apart. Each `id_out` matches its grant.
- `ready_in` = 0 for 5 cycles in DONE while `req_in` = 0110 → outputs held constant and no grant issued. After `ready_in` rises, the next grant goes to requester 1 if the last winner was 0.
- `rst_n_in` low for 1 cycle during EXEC → all outputs 0 immediately (asynchronous). The aborted result never appears. Afterwards the `ptr` = 0 arbitration restarts.
- Requester 2 operands changed on the cycle after its grant → `data_out` reflects the values latched at the grant edge.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and default sizing.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NReqDefault = 4;
  localparam int unsigned IdwDefault  = 2;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle for the adder arbiter.
//   req_in/data1_in/data2_in : per-requester request level and packed operands (k at [32k+31:32k])
//   grant_out                : one-hot grant pulse
//   data_out/carry_out/id_out: registered result, carry and owning requester
//   valid_out/ready_in       : result handshake
//   busy_out                 : arbiter not idle
// The arbiter uses the slave modport; the requesting side uses master.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault,
  parameter int unsigned IDW  = IdwDefault
);
  logic [NREQ-1:0]    req_in;
  logic [NREQ*32-1:0] data1_in;
  logic [NREQ*32-1:0] data2_in;
  logic [NREQ-1:0]    grant_out;
  logic [31:0]        data_out;
  logic               carry_out;
  logic [IDW-1:0]     id_out;
  logic               valid_out;
  logic               ready_in;
  logic               busy_out;

  modport slave (
    input  req_in, data1_in, data2_in, ready_in,
    output grant_out, data_out, carry_out, id_out, valid_out, busy_out
  );

  modport master (
    output req_in, data1_in, data2_in, ready_in,
    input  grant_out, data_out, carry_out, id_out, valid_out, busy_out
  );
endinterface

// File: rtl/Adder.sv
// Existing shared 32-bit adder datapath (sum modulo 2^32, no carry output).
//   a, b : operands
//   s    : a + b
module Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  assign s = a + b;
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: selects the first set request at or after ptr_i,
// wrapping modulo NREQ.
//   req_i : request vector
//   ptr_i : highest-priority index
//   gnt_o : one-hot winner
//   idx_o : winner index
//   any_o : at least one request set
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one 32-bit Adder among NREQ requesters. Round-robin grant in IDLE latches the
// winner's operands, EXEC registers the sum/carry/id, DONE holds the result until
// valid_out & ready_in, after which the pointer moves past the winner.
//   clk_in, rst_n_in : clock, async active-low reset
//   bus_io           : requester/consumer bundle (see adder_arbiter_if)
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault,
  parameter int unsigned IDW  = IdwDefault
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  adder_arbiter_if.slave bus_io
);
  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win_q;
  logic [31:0]    a_q, b_q;
  logic [31:0]    data_q;
  logic           carry_q;
  logic [IDW-1:0] id_q;
  logic           valid_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [31:0]     a_sel, b_sel;
  logic [31:0]     sum;
  logic            carry;
  logic [IDW-1:0]  ptr_next;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req_i(bus_io.req_in),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  Adder u_adder (
    .a(a_q),
    .b(b_q),
    .s(sum)
  );

  // Bit 32 of {1'b0,a}+{1'b0,b}, recovered from the operand MSBs and the sum MSB.
  assign carry = (a_q[31] & b_q[31]) | ((a_q[31] ^ b_q[31]) & ~sum[31]);

  assign ptr_next = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);

  // Operand mux driven directly by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_gnt[k]) begin
        a_sel = bus_io.data1_in[32*k +: 32];
        b_sel = bus_io.data2_in[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            win_q   <= pick_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          data_q  <= sum;
          carry_q <= carry;
          id_q    <= win_q;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (bus_io.ready_in) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by reset so the grant also reads zero while reset is held with requests pending.
  assign bus_io.grant_out = (state_q == StIdle && rst_n_in) ? pick_gnt : '0;
  assign bus_io.data_out  = data_q;
  assign bus_io.carry_out = carry_q;
  assign bus_io.id_out    = id_q;
  assign bus_io.valid_out = valid_q;
  assign bus_io.busy_out  = (state_q != StIdle);

endmodule
